// File: rtl/rf_writeback_if.sv
// Writeback bus between the execute/memory stages and the register-file write port.
// Signals:
//   alu_valid/alu_rd/alu_data    ALU result, one cycle, never stalled
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  handshaked LSU result
//   wb_en/rd_index/wb_data       registered register-file write port
//   pending_mask                 registers with a queued LSU write
//   fifo_count                   LSU FIFO occupancy
// Modports: master = producers and register file (drives results),
//           slave  = the writeback arbiter.
interface rf_writeback_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    logic                     alu_valid;
    logic [4:0]               alu_rd;
    logic [XLEN-1:0]          alu_data;
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [4:0]               lsu_rd;
    logic [XLEN-1:0]          lsu_data;
    logic                     wb_en;
    logic [4:0]               rd_index;
    logic [XLEN-1:0]          wb_data;
    logic [31:0]              pending_mask;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready, wb_en, rd_index, wb_data, pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output lsu_ready, wb_en, rd_index, wb_data, pending_mask, fifo_count
    );
endinterface

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter.
// The ALU result has absolute priority on the single write port; LSU results are
// accepted into a DEPTH-entry FIFO and drained into cycles the ALU leaves idle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rf_writeback_if.slave: ALU/LSU result inputs, registered write port,
//        lsu_ready, pending_mask and fifo_count status outputs
module rf_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input logic         clk,
    input logic         rst,
    rf_writeback_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [4:0]      mem_rd_q   [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            wb_en_q;
    logic [4:0]      rd_index_q;
    logic [XLEN-1:0] wb_data_q;

    logic            lsu_ready;
    logic            enq;
    logic            deq;
    logic            alu_issue;
    logic [31:0]     pending_mask;

    // Ready depends on occupancy only: a full FIFO does not accept even if it
    // dequeues in the same cycle.
    assign lsu_ready = (count_q < CW'(DEPTH));
    // Writes to x0 are consumed but never stored.
    assign enq       = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
    assign alu_issue = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign deq       = !alu_issue && (count_q != CW'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end

    // Storage is not reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_data_q[wr_ptr_q] <= bus.lsu_data;
            mem_rd_q[wr_ptr_q]   <= bus.lsu_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            rd_index_q <= 5'd0;
            wb_data_q  <= '0;
        end else if (alu_issue) begin
            wb_en_q    <= 1'b1;
            rd_index_q <= bus.alu_rd;
            wb_data_q  <= bus.alu_data;
        end else if (deq) begin
            wb_en_q    <= 1'b1;
            rd_index_q <= mem_rd_q[rd_ptr_q];
            wb_data_q  <= mem_data_q[rd_ptr_q];
        end else begin
            // Index and data hold so the write port stays quiet when idle.
            wb_en_q    <= 1'b0;
        end
    end

    // An entry is valid when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [AW-1:0] offset;
            offset = AW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) begin
                pending_mask[mem_rd_q[i]] = 1'b1;
            end
        end
    end

    assign bus.lsu_ready    = lsu_ready;
    assign bus.wb_en        = wb_en_q;
    assign bus.rd_index     = rd_index_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.pending_mask = pending_mask;
    assign bus.fifo_count   = count_q;
endmodule
